btn_conditioner: RTL
====================

// Module: btn_conditioner
// PURPOSE
//  Parametrised N-channel pushbutton front end for the game top level. Per channel: synchroniser, debounce FSM,
//  press/release pulses and optional auto-repeat fire pulses. Sits between board buttons (btnL/btnS/btnU/...) and
//  the VGA/game controller, replacing raw button wiring. All outputs are synchronous to clk.
// PARAMETERS
//  N_BTN          3          number of button channels
//  SYNC_STAGES    2          flip-flop synchroniser depth, legal >=2
//  DB_CYCLES      1000000    clk cycles input must be stable to accept an edge (10 ms @100 MHz), legal >=2
//  REPEAT_DELAY   50000000   clk cycles held before first auto-repeat pulse (0.5 s)
//  REPEAT_PERIOD  10000000   clk cycles between subsequent auto-repeat pulses (0.1 s), legal >=1
// PORTS
//  clk          in   1      master clock, 100 MHz
//  rst          in   1      asynchronous, active-high reset
//  btn_in       in   N_BTN  raw asynchronous button levels, 1 = pressed
//  btn_level    out  N_BTN  debounced level
//  btn_press    out  N_BTN  1-cycle pulse on accepted press
//  btn_release  out  N_BTN  1-cycle pulse on accepted release
//  btn_fire     out  N_BTN  btn_press OR auto-repeat pulse, 1 cycle each
// BEHAVIOUR
//  Interface: one clock, clk. Reset is rst: asynchronous, active-high. All flops clear on rst; outputs all 0 in reset.
//  Sync: btn_in -> SYNC_STAGES flops -> s[i]; sync chain resets to 0.
//  Per-channel FSM {IDLE, PRESS_DB, HELD, REL_DB}; counter cnt, width $clog2(DB_CYCLES).
//   IDLE:     s=1 -> PRESS_DB, cnt<=0.
//   PRESS_DB: s=0 -> IDLE (glitch rejected, no pulse); else cnt++; cnt==DB_CYCLES-1 -> HELD, btn_press=1 one cycle.
//   HELD:     s=0 -> REL_DB, cnt<=0.
//   REL_DB:   s=1 -> HELD (no pulse, level stays 1); cnt==DB_CYCLES-1 -> IDLE, btn_release=1 one cycle.
//  btn_level = 1 in HELD and REL_DB, else 0; registered, changes in same cycle as press/release pulse.
//  Latency: clean edge on btn_in -> pulse exactly SYNC_STAGES+DB_CYCLES clk cycles later (+/-1 for async sampling).
//  Pulses are registered; press and release never both high on a channel; channels fully independent,
//   simultaneous events on different channels all reported in the same cycle.
//  Auto-repeat: rcnt, width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1); cleared on entry to HELD from PRESS_DB.
//   Counts only in HELD; frozen in REL_DB (bounce during hold does not restart the delay); cleared in IDLE.
//   First repeat pulse REPEAT_DELAY cycles after btn_press; subsequent ones every REPEAT_PERIOD cycles; no
//   repeat pulse in the btn_press cycle; counter wrap uses reload, never free-running overflow.
//  rst asserted mid-debounce or mid-hold: FSM -> IDLE immediately; after release, a still-held button must
//   re-debounce and produces a fresh btn_press.
// CONFIGURATION
//  `BTN_AUTOREPEAT_EN defined: auto-repeat logic built; btn_fire = press | repeat.
//  Not defined: rcnt logic and REPEAT_* parameters unused; btn_fire == btn_press exactly.
// STRUCTURE
//  Package btn_pkg: FSM state typedef (2-bit enum), state encodings, shared width helper for counters.
//  Sub-module btn_channel (sync chain + FSM + counters for one button), instantiated N_BTN times via generate;
//   btn_conditioner is the generate wrapper only.
// TESTING  (bench params: N_BTN=3, SYNC_STAGES=2, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
//  1 Hold rst 5 cycles, btn_in=3'b111 -> all outputs 0 throughout; after release, press pulses 6 cycles later.
//  2 btn_in[0] high for 3 cycles then low -> no btn_press, btn_level[0] stays 0 (glitch reject).
//  3 btn_in[1] rises at t0, stays high -> btn_press[1]=1 at t0+6 only, btn_level[1]=1 from t0+6; drop ->
//     btn_release[1] one cycle 6 cycles later, level 0.
//  4 (AUTOREPEAT_EN) hold btn_in[2] 40 cycles after press -> btn_fire[2] at press, +10, +15, +20, +25, ...
//     ; 2-cycle low glitch at +12 -> no release, next repeat at +17 (counter frozen 2 cycles).
//  5 btn_in=3'b101 rising same cycle -> btn_press=3'b101 in a single cycle; channel 1 untouched.
//  6 rst pulse while channel 0 in HELD -> level 0 async; button still high -> new btn_press 6 cycles after
//     rst release. Without macro: repeat of scenario 4 -> btn_fire only at press.

Source files
------------

// File: rtl/btn_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
//  Module   : btn_pkg
//  Brief    : Shared debounce FSM state type and counter width helper.
//  Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package btn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PRESS_DB = 2'd1,
      ST_HELD     = 2'd2,
      ST_REL_DB   = 2'd3
   } btn_state_t;

   // Bits needed to count 0..n-1, never less than one bit.
   function automatic int cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
//  Module   : btn_channel
//  Brief    : One button: synchroniser, debounce FSM, press/release pulses,
//             auto-repeat fire pulses when BTN_AUTOREPEAT_EN is defined.
//  Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module btn_channel
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int DB_CYCLES     = 1000000,
   parameter int REPEAT_DELAY  = 50000000,
   parameter int REPEAT_PERIOD = 10000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_fire
);

   localparam int              c_CW      = cnt_width(DB_CYCLES);
   localparam logic [c_CW-1:0] c_DB_LAST = c_CW'(DB_CYCLES - 1);

   if (SYNC_STAGES < 2 || DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
      $error("btn_channel: illegal parameter value");
   end

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;
   btn_state_t             r_state;
   btn_state_t             w_state_nxt;
   logic [c_CW-1:0]        r_cnt;
   logic [c_CW-1:0]        w_cnt_nxt;
   logic                   w_level_nxt;
   logic                   w_press_nxt;
   logic                   w_release_nxt;
   logic                   w_fire_nxt;
   logic                   r_level;
   logic                   r_press;
   logic                   r_release;
   logic                   r_fire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
      end
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_s) begin
               w_state_nxt = ST_PRESS_DB;
               w_cnt_nxt   = '0;
            end
         end
         ST_PRESS_DB: begin
            if (!w_s)                    w_state_nxt = ST_IDLE;
            else if (r_cnt == c_DB_LAST) w_state_nxt = ST_HELD;
            else                         w_cnt_nxt   = r_cnt + c_CW'(1);
         end
         ST_HELD: begin
            if (!w_s) begin
               w_state_nxt = ST_REL_DB;
               w_cnt_nxt   = '0;
            end
         end
         ST_REL_DB: begin
            if (w_s)                     w_state_nxt = ST_HELD;
            else if (r_cnt == c_DB_LAST) w_state_nxt = ST_IDLE;
            else                         w_cnt_nxt   = r_cnt + c_CW'(1);
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are computed one cycle early and registered, so level and pulses
   // change together on the cycle the FSM settles into HELD or IDLE.
   always_comb begin
      w_level_nxt   = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_REL_DB);
      w_press_nxt   = (r_state == ST_PRESS_DB) && (w_state_nxt == ST_HELD);
      w_release_nxt = (r_state == ST_REL_DB) && (w_state_nxt == ST_IDLE);
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int              c_RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int              c_RW          = cnt_width(c_RMAX + 1);
   localparam logic [c_RW-1:0] c_DELAY_LAST  = c_RW'(REPEAT_DELAY - 1);
   localparam logic [c_RW-1:0] c_PERIOD_LAST = c_RW'(REPEAT_PERIOD - 1);

   logic [c_RW-1:0] r_rcnt;
   logic            r_rarmed;
   logic            w_rep_hit;

   assign w_rep_hit = (r_state == ST_HELD) &&
                      (r_rcnt == (r_rarmed ? c_PERIOD_LAST : c_DELAY_LAST));

   // Frozen in REL_DB so a bounce while held does not restart the delay.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rcnt   <= '0;
         r_rarmed <= 1'b0;
      end else begin
         case (r_state)
            ST_HELD: begin
               if (w_rep_hit) begin
                  r_rcnt   <= '0;
                  r_rarmed <= 1'b1;
               end else begin
                  r_rcnt   <= r_rcnt + c_RW'(1);
               end
            end
            ST_REL_DB: begin
               r_rcnt   <= r_rcnt;
               r_rarmed <= r_rarmed;
            end
            default: begin
               r_rcnt   <= '0;
               r_rarmed <= 1'b0;
            end
         endcase
      end
   end

   assign w_fire_nxt = w_press_nxt | w_rep_hit;
`else
   assign w_fire_nxt = w_press_nxt;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_fire    <= 1'b0;
      end else begin
         r_level   <= w_level_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
         r_fire    <= w_fire_nxt;
      end
   end

   assign btn_level   = r_level;
   assign btn_press   = r_press;
   assign btn_release = r_release;
   assign btn_fire    = r_fire;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
//  Module   : btn_conditioner
//  Brief    : N-channel pushbutton front end; one btn_channel per button.
//             Define BTN_AUTOREPEAT_EN to build the auto-repeat fire logic.
//  Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module btn_conditioner #(
   parameter int N_BTN         = 3,
   parameter int SYNC_STAGES   = 2,
   parameter int DB_CYCLES     = 1000000,
   parameter int REPEAT_DELAY  = 50000000,
   parameter int REPEAT_PERIOD = 10000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_fire
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_channel #(
         .SYNC_STAGES   (SYNC_STAGES),
         .DB_CYCLES     (DB_CYCLES),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .btn_in      (btn_in[i]),
         .btn_level   (btn_level[i]),
         .btn_press   (btn_press[i]),
         .btn_release (btn_release[i]),
         .btn_fire    (btn_fire[i])
      );
   end

endmodule
`default_nettype wire
